parallel_module: RTL and testbench
==================================

# parallel_module

Parallel 2-D convolution engine. It stores a 4x4 matrix A and a 3x3 kernel B, both with 8-bit unsigned elements. On command it computes all four valid-window sums in parallel, giving a 2x2 result. A select code then picks which result, or which reduction of the results, appears on a registered 8-bit output port. It sits as a memory-mapped compute leaf: the host drives all operands in parallel and reads one byte per cycle.

## Interface
No parameters; all widths are fixed.
- clk  in  1  single system clock; all state updates on its rising edge
- rst  in  1  reset, synchronous, active-low
- preset  in  1  synchronous, active-high; loads the identity kernel into B
- a11..a44  in  8 each  matrix A operands (row, column), unsigned
- b11..b33  in  8 each  kernel B operands (row, column), unsigned
- s1  in  4  load-target select for we_1
- we_1  in  1  operand write enable
- we_2  in  1  compute/commit enable
- s0  in  4  output select
- out  out  8  registered result byte

## Operation
- **Register priority each edge:** rst=0 > preset=1 > we_1 (A/B registers); we_2 is evaluated in the same edge, independently of we_1.
- **Reset (rst=0):** clear A regs, B regs, the four raw results R11/R12/R21/R22, the overflow flags OV[3:0] and out, all to 0.
- **preset=1:** B becomes the identity kernel (b22 register=1, the other eight =0). A is unchanged; any we_1 in the same cycle is ignored.
- **we_1=1, load target by s1:**
  - s1=0: load A and B.
  - s1=1: load A only.
  - s1=2: load B only.
  - s1=3..15: no load.
- **we_2=1:** latch the four raw 20-bit sums computed from the stored registers, not the input ports.
  - Rij = Σ(m,n=1..3) A[i+m-1][j+n-1] × B[m][n], for i,j ∈ {1,2}.
  - Arithmetic is unsigned; the maximum is 585225, so 20 bits never overflow.
  - OV[k] = (Rk > 255), where k=0:R11, 1:R12, 2:R21, 3:R22.
- **Same-edge we_1 and we_2:** we_2 uses the pre-edge register values. The new operands affect only the next commit.
- **Output, every edge out <= f(s0), with sat(x)=min(x,255):**
  - s0=0: sat(R11). s0=1: sat(R12). s0=2: sat(R21). s0=3: sat(R22).
  - s0=4: sat(max of the four R).
  - s0=5: sat(min of the four R).
  - s0=6: sat((R11+R12+R21+R22)>>2); the sum uses a 22-bit accumulator and truncating division.
  - s0=7: {4'b0, OV[3:0]}.
  - s0=8..15: 8'h00.
- Results hold until the next we_2 or reset. out tracks s0 continuously; it is not gated by any enable.

## Timing
- Operand load: new A/B values are visible to the compute datapath one cycle after the we_1 edge.
- Earliest valid commit: we_2 one cycle after we_1.
- Commit-to-output: out reflects new results one edge after the commit edge, provided s0 is stable. s0 change to out: 1 cycle.
- Maximum read rate: one byte per cycle, with s0 changing every cycle.
- Reset value: out = 8'h00 after the first edge with rst=0. Reset asserted mid-sequence discards all stored operands and results on that edge.
- The compute datapath is combinational between the A/B registers and the result registers, so it must close timing in one clock period. This is 36 8x8 multipliers plus adder trees (no multicycle path).

## Test plan
- **Reset:** rst=0 for 1 edge with any inputs → out=0. Then each s0=0..7 reads 0.
- **Main load/commit/read.** A rows {1,2,3,4}, {2,3,4,5}, {3,4,5,5}, {3,4,5,5}; B rows {9,8,7}, {8,7,6}, {7,6,5}. Sequence: we_1 with s1=1, we_1 with s1=0, then we_2. Required reads:

  | s0 | out | note |
  |---|---|---|
  | 0 | 177 | |
  | 1 | 235 | |
  | 2 | 222 | |
  | 3 | 255 | raw 274, saturated |
  | 4 | 255 | |
  | 5 | 177 | |
  | 6 | 227 | |
  | 7 | 8 | |

- **Preset identity:** with the A above, pulse preset, then we_2. Required reads: s0=0→3, s0=1→4, s0=2→4, s0=3→5, s0=7→0.
- **Selective load:** we_1 with s1=2 and new B all 1s, A unchanged, then we_2. Required read: s0=0→27, the sum of the A top-left 3x3. we_1 with s1=5 → no register change.
- **Same-edge we_1/we_2:** the commit uses the old operands. A second we_2 one cycle later shows the new operands.
- **Select sweep:** step s0 through 0→1→2→4→5→6→1→2→3→5→6→7 one per cycle. out lags by exactly 1 cycle; s0=9 → 0.

Source files
------------

// File: rtl/parallel_module.sv
// rtl/parallel_module.sv - parallel 2-D convolution engine (4x4 A, 3x3 kernel B, 2x2 result)
//
// Stores matrix A and kernel B, computes all four valid-window sums in one
// cycle on we_2, and presents a selected result or reduction on a registered
// byte output.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active low
//   preset     synchronous, loads the identity kernel into B
//   a11..a44   matrix A operands (8-bit unsigned)
//   b11..b33   kernel B operands (8-bit unsigned)
//   s1         load target for we_1 (0: A+B, 1: A, 2: B, others: none)
//   we_1       operand write enable
//   we_2       compute/commit enable
//   s0         output select
//   out        registered result byte

module parallel_module (
  input  logic       clk,
  input  logic       rst,
  input  logic       preset,
  input  logic [7:0] a11, a12, a13, a14,
  input  logic [7:0] a21, a22, a23, a24,
  input  logic [7:0] a31, a32, a33, a34,
  input  logic [7:0] a41, a42, a43, a44,
  input  logic [7:0] b11, b12, b13,
  input  logic [7:0] b21, b22, b23,
  input  logic [7:0] b31, b32, b33,
  input  logic [3:0] s1,
  input  logic       we_1,
  input  logic       we_2,
  input  logic [3:0] s0,
  output logic [7:0] out
);

  logic [7:0]  a_in [4][4];
  logic [7:0]  b_in [3][3];
  logic [7:0]  a_q  [4][4];
  logic [7:0]  b_q  [3][3];
  logic [19:0] r_q  [4];
  logic [3:0]  ov_q;
  logic [19:0] sum_c [4];
  logic [19:0] r_max;
  logic [19:0] r_min;
  logic [21:0] r_sum;
  logic [19:0] r_avg;
  logic [7:0]  out_next;

  assign a_in[0][0] = a11;
  assign a_in[0][1] = a12;
  assign a_in[0][2] = a13;
  assign a_in[0][3] = a14;
  assign a_in[1][0] = a21;
  assign a_in[1][1] = a22;
  assign a_in[1][2] = a23;
  assign a_in[1][3] = a24;
  assign a_in[2][0] = a31;
  assign a_in[2][1] = a32;
  assign a_in[2][2] = a33;
  assign a_in[2][3] = a34;
  assign a_in[3][0] = a41;
  assign a_in[3][1] = a42;
  assign a_in[3][2] = a43;
  assign a_in[3][3] = a44;

  assign b_in[0][0] = b11;
  assign b_in[0][1] = b12;
  assign b_in[0][2] = b13;
  assign b_in[1][0] = b21;
  assign b_in[1][1] = b22;
  assign b_in[1][2] = b23;
  assign b_in[2][0] = b31;
  assign b_in[2][1] = b32;
  assign b_in[2][2] = b33;

  function automatic logic [7:0] sat20(input logic [19:0] x);
    return (x > 20'd255) ? 8'hFF : x[7:0];
  endfunction

  // Four windows in parallel, always from the stored registers so a
  // same-edge operand load never leaks into the commit.
  always_comb begin
    for (int k = 0; k < 4; k++) sum_c[k] = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        for (int m = 0; m < 3; m++)
          for (int n = 0; n < 3; n++)
            sum_c[i*2+j] = sum_c[i*2+j] + 20'(a_q[i+m][j+n]) * 20'(b_q[m][n]);
  end

  always_comb begin
    r_max = r_q[0];
    r_min = r_q[0];
    r_sum = '0;
    for (int k = 0; k < 4; k++) begin
      if (r_q[k] > r_max) r_max = r_q[k];
      if (r_q[k] < r_min) r_min = r_q[k];
      r_sum = r_sum + 22'(r_q[k]);
    end
    // Max of 4*585225 fits in 22 bits; after >>2 it fits back in 20.
    r_avg = 20'(r_sum >> 2);

    out_next = 8'h00;
    case (s0)
      4'd0, 4'd1, 4'd2, 4'd3: out_next = sat20(r_q[s0[1:0]]);
      4'd4:    out_next = sat20(r_max);
      4'd5:    out_next = sat20(r_min);
      4'd6:    out_next = sat20(r_avg);
      4'd7:    out_next = {4'b0000, ov_q};
      default: out_next = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          a_q[i][j] <= '0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          b_q[i][j] <= '0;
      for (int k = 0; k < 4; k++) r_q[k] <= '0;
      ov_q <= '0;
      out  <= '0;
    end else begin
      if (preset) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            b_q[i][j] <= (i == 1 && j == 1) ? 8'd1 : 8'd0;
      end else if (we_1) begin
        if (s1 == 4'd0 || s1 == 4'd1) begin
          for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
              a_q[i][j] <= a_in[i][j];
        end
        if (s1 == 4'd0 || s1 == 4'd2) begin
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              b_q[i][j] <= b_in[i][j];
        end
      end

      if (we_2) begin
        for (int k = 0; k < 4; k++) begin
          r_q[k]  <= sum_c[k];
          ov_q[k] <= (sum_c[k] > 20'd255);
        end
      end

      out <= out_next;
    end
  end

endmodule

// File: tb/tb_parallel_module.sv
// tb/tb_parallel_module.sv - randomized self-checking bench for parallel_module

module tb_parallel_module;

  logic       clk = 1'b0;
  logic       rst;
  logic       preset;
  logic [7:0] pa [4][4];
  logic [7:0] pb [3][3];
  logic [3:0] s1;
  logic       we_1;
  logic       we_2;
  logic [3:0] s0;
  logic [7:0] out;

  int checks = 0;
  int errors = 0;

  int ma [4][4];
  int mb [3][3];
  int mr [4];
  logic [7:0] exp_out;

  int main_a [4][4] = '{'{1,2,3,4}, '{2,3,4,5}, '{3,4,5,5}, '{3,4,5,5}};
  int main_b [3][3] = '{'{9,8,7}, '{8,7,6}, '{7,6,5}};
  int main_tbl [8]  = '{177, 235, 222, 255, 255, 177, 227, 8};
  int pre_sel  [5]  = '{0, 1, 2, 3, 7};
  int pre_tbl  [5]  = '{3, 4, 4, 5, 0};
  int sweep    [12] = '{0, 1, 2, 4, 5, 6, 1, 2, 3, 5, 6, 7};

  always #5 clk = ~clk;

  parallel_module dut (
    .clk(clk), .rst(rst), .preset(preset),
    .a11(pa[0][0]), .a12(pa[0][1]), .a13(pa[0][2]), .a14(pa[0][3]),
    .a21(pa[1][0]), .a22(pa[1][1]), .a23(pa[1][2]), .a24(pa[1][3]),
    .a31(pa[2][0]), .a32(pa[2][1]), .a33(pa[2][2]), .a34(pa[2][3]),
    .a41(pa[3][0]), .a42(pa[3][1]), .a43(pa[3][2]), .a44(pa[3][3]),
    .b11(pb[0][0]), .b12(pb[0][1]), .b13(pb[0][2]),
    .b21(pb[1][0]), .b22(pb[1][1]), .b23(pb[1][2]),
    .b31(pb[2][0]), .b32(pb[2][1]), .b33(pb[2][2]),
    .s1(s1), .we_1(we_1), .we_2(we_2), .s0(s0), .out(out)
  );

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, want);
    end
  endtask

  function automatic int sat(input longint x);
    return (x > 255) ? 255 : int'(x);
  endfunction

  function automatic int window(input int i, input int j);
    int acc = 0;
    for (int m = 0; m < 3; m++)
      for (int n = 0; n < 3; n++)
        acc += ma[i+m][j+n] * mb[m][n];
    return acc;
  endfunction

  function automatic logic [7:0] model_out(input int sel);
    int q[$];
    longint total = 0;
    int ovb = 0;
    for (int k = 0; k < 4; k++) begin
      q.push_back(mr[k]);
      total += mr[k];
      if (mr[k] > 255) ovb += (1 << k);
    end
    q.sort();
    case (sel)
      0, 1, 2, 3: return 8'(sat(mr[sel]));
      4:          return 8'(sat(q[3]));
      5:          return 8'(sat(q[0]));
      6:          return 8'(sat(total / 4));
      7:          return 8'(ovb);
      default:    return 8'd0;
    endcase
  endfunction

  // Applies one clock edge to the reference model using the inputs held at that edge.
  task automatic model_edge();
    int nr [4];
    if (!rst) begin
      for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) ma[i][j] = 0;
      for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) mb[i][j] = 0;
      for (int k = 0; k < 4; k++) mr[k] = 0;
      exp_out = 8'd0;
    end else begin
      exp_out = model_out(int'(s0));
      if (we_2) begin
        nr[0] = window(0, 0);
        nr[1] = window(0, 1);
        nr[2] = window(1, 0);
        nr[3] = window(1, 1);
        for (int k = 0; k < 4; k++) mr[k] = nr[k];
      end
      if (preset) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            mb[i][j] = (i == 1 && j == 1) ? 1 : 0;
      end else if (we_1) begin
        if (s1 == 0 || s1 == 1)
          for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) ma[i][j] = int'(pa[i][j]);
        if (s1 == 0 || s1 == 2)
          for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) mb[i][j] = int'(pb[i][j]);
      end
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_val(tag, out, exp_out);
  endtask

  task automatic idle();
    rst = 1'b1; preset = 1'b0; we_1 = 1'b0; we_2 = 1'b0; s1 = 4'd15;
  endtask

  function automatic logic [7:0] rnd8();
    if ($urandom_range(0, 3) == 0) return 8'($urandom_range(0, 255));
    return 8'($urandom_range(0, 9));
  endfunction

  task automatic rand_ports();
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) pa[i][j] = rnd8();
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) pb[i][j] = rnd8();
  endtask

  initial begin
    rst = 1'b0; preset = 1'b0; we_1 = 1'b0; we_2 = 1'b0; s1 = '0; s0 = '0;
    rand_ports();
    #2;

    // Reset with arbitrary inputs, then read every select.
    we_1 = 1'b1; we_2 = 1'b1; preset = 1'b1; s0 = 4'd7;
    cycle("reset");
    check_val("reset_zero", out, 8'd0);
    idle();
    for (int k = 0; k < 8; k++) begin
      s0 = 4'(k);
      cycle("reset_read");
      check_val("reset_read_zero", out, 8'd0);
    end

    // Main load / commit / read.
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) pa[i][j] = 8'(main_a[i][j]);
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) pb[i][j] = 8'(main_b[i][j]);
    we_1 = 1'b1; s1 = 4'd1; cycle("main_load_a");
    s1 = 4'd0; cycle("main_load_ab");
    idle(); we_2 = 1'b1; cycle("main_commit");
    idle();
    for (int k = 0; k < 8; k++) begin
      s0 = 4'(k);
      cycle("main_model");
      check_val("main_table", out, 8'(main_tbl[k]));
    end

    // Preset identity kernel; A ports scrambled to show A is untouched.
    rand_ports();
    preset = 1'b1; we_1 = 1'b1; s1 = 4'd0; cycle("preset");
    idle(); we_2 = 1'b1; cycle("preset_commit");
    idle();
    for (int k = 0; k < 5; k++) begin
      s0 = 4'(pre_sel[k]);
      cycle("preset_model");
      check_val("preset_table", out, 8'(pre_tbl[k]));
    end

    // Selective B-only load, then an ignored load target.
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) pa[i][j] = 8'd200;
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) pb[i][j] = 8'd1;
    s0 = 4'd0;
    we_1 = 1'b1; s1 = 4'd2; cycle("sel_load_b");
    idle(); we_2 = 1'b1; cycle("sel_commit");
    idle(); cycle("sel_read");
    check_val("sel_b_ones", out, 8'd27);
    rand_ports();
    we_1 = 1'b1; s1 = 4'd5; cycle("sel_noload");
    idle(); we_2 = 1'b1; cycle("sel_noload_commit");
    idle(); cycle("sel_noload_read");
    check_val("sel_noload_27", out, 8'd27);

    // Same-edge load and commit: commit sees the old kernel.
    for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) pa[i][j] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) pb[i][j] = 8'd2;
    we_1 = 1'b1; we_2 = 1'b1; s1 = 4'd2; cycle("same_edge");
    idle(); we_2 = 1'b1; cycle("same_edge_old");
    check_val("same_edge_old_27", out, 8'd27);
    idle(); cycle("same_edge_new");
    check_val("same_edge_new_54", out, 8'd54);

    // Select sweep, one select per cycle.
    for (int k = 0; k < 12; k++) begin
      s0 = 4'(sweep[k]);
      cycle("sweep");
    end
    s0 = 4'd9; cycle("sweep_s9");
    check_val("sweep_s9_zero", out, 8'd0);

    // Randomized traffic including mid-sequence resets.
    for (int t = 0; t < 400; t++) begin
      rand_ports();
      rst    = ($urandom_range(0, 39) != 0);
      preset = ($urandom_range(0, 9) == 0);
      we_1   = ($urandom_range(0, 2) == 0);
      we_2   = ($urandom_range(0, 2) == 0);
      s1     = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
      s0     = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 7));
      cycle("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
